gpu_cmd_scheduler: RTL

Command queue and sequencer in front of the `gpu` block. It accepts DRAW, CLEAR and SWAP commands from the CPU bus through a valid/ready push port and buffers them in a FIFO. It issues them one at a time to the GPU control port, holding every `ctrl_*` field stable until the GPU drops busy. SWAP commands are deferred to the next vblank and then pulse the framebuffer swap.

---
 rtl/gpu_sched_pkg.sv | 28 ++
 rtl/gpu_cmd_fifo.sv | 39 +++
 rtl/gpu_cmd_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/gpu_sched_pkg.sv
// gpu_sched_pkg: command encodings, scheduler states and the FIFO word shared by the GPU command scheduler
package gpu_sched_pkg;
  typedef enum logic [1:0] {
    CMD_DRAW  = 2'd0,
    CMD_CLEAR = 2'd1,
    CMD_SWAP  = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_type_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_VWAIT
  } state_e;
  typedef struct packed {
    cmd_type_e   typ;
    logic [31:0] address;
    logic [15:0] address_x;
    logic [15:0] address_y;
    logic [15:0] sheetsize;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] color;
  } cmd_t;
endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: synchronous FIFO with occupancy level; overflow pushes and underflow pops are ignored
module gpu_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/gpu_cmd_scheduler.sv
// gpu_cmd_scheduler: queues CPU draw/clear/swap commands and issues them one at a time to the GPU
module gpu_cmd_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [31:0] cmd_address,
  input  logic [15:0] cmd_address_x,
  input  logic [15:0] cmd_address_y,
  input  logic [15:0] cmd_sheetsize,
  input  logic [15:0] cmd_width,
  input  logic [15:0] cmd_height,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  input  logic [15:0] cmd_color,
  output logic [31:0] ctrl_address,
  output logic [15:0] ctrl_address_x,
  output logic [15:0] ctrl_address_y,
  output logic [15:0] ctrl_sheetsize,
  output logic [15:0] ctrl_width,
  output logic [15:0] ctrl_height,
  output logic [15:0] ctrl_x,
  output logic [15:0] ctrl_y,
  output logic [15:0] ctrl_clear_color,
  output logic        ctrl_draw,
  output logic        ctrl_clear,
  input  logic        ctrl_busy,
  input  logic        vblank,
  output logic        fb_swap,
  output logic [AW:0] queue_level,
  output logic        sched_idle
);
  state_e state, state_nx;
  cmd_t wr_cmd, head;
  cmd_type_e cur_type;
  logic full, empty, pop, vblank_q, vblank_rise;
  assign wr_cmd = '{typ: cmd_type_e'(cmd_type), address: cmd_address, address_x: cmd_address_x,
                    address_y: cmd_address_y, sheetsize: cmd_sheetsize, width: cmd_width,
                    height: cmd_height, x: cmd_x, y: cmd_y, color: cmd_color};
  assign cmd_ready = !full;
  assign pop = state == S_IDLE && !empty && !ctrl_busy;
  assign vblank_rise = vblank && !vblank_q;
  gpu_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t)), .AW(AW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cmd_valid),
    .pop   (pop),
    .din   (wr_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (queue_level)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pop) state_nx = head.typ == CMD_SWAP ? S_VWAIT : head.typ == CMD_RSVD ? S_IDLE : S_ISSUE;
      S_ISSUE: state_nx = S_ARM;
      S_ARM:   state_nx = S_WAIT;
      S_WAIT:  if (!ctrl_busy) state_nx = S_IDLE;
      S_VWAIT: if (vblank_rise) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    ctrl_draw = state == S_ISSUE && cur_type == CMD_DRAW;
    ctrl_clear = state == S_ISSUE && cur_type == CMD_CLEAR;
    sched_idle = empty && state == S_IDLE && !ctrl_busy;
  end
  // ctrl_* fields only move on a real pop; reserved entries leave them untouched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_type <= CMD_DRAW;
      ctrl_address <= '0;
      ctrl_address_x <= '0;
      ctrl_address_y <= '0;
      ctrl_sheetsize <= '0;
      ctrl_width <= '0;
      ctrl_height <= '0;
      ctrl_x <= '0;
      ctrl_y <= '0;
      ctrl_clear_color <= '0;
      vblank_q <= 1'b0;
      fb_swap <= 1'b0;
    end else begin
      vblank_q <= vblank;
      fb_swap <= state == S_VWAIT && vblank_rise;
      if (pop && head.typ != CMD_RSVD) begin
        cur_type <= head.typ;
        ctrl_address <= head.address;
        ctrl_address_x <= head.address_x;
        ctrl_address_y <= head.address_y;
        ctrl_sheetsize <= head.sheetsize;
        ctrl_width <= head.width;
        ctrl_height <= head.height;
        ctrl_x <= head.x;
        ctrl_y <= head.y;
        ctrl_clear_color <= head.color;
      end
    end
  end
endmodule
